hazard_controller: RTL and testbench

- Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall, flush and forward controls of the fetch, decode, execute and memory stage registers.
- Resolves RAW hazards by forwarding, inserts load-use bubbles and flushes on taken branches.
- Freezes the whole pipeline while data memory is not ready, with a timeout watchdog.
- Keeps saturating performance counters for stalls and flushes.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/forward_unit.sv | 34 +++
 rtl/hazard_controller.sv | 166 ++++++++++++++++
 tb/tb_hazard_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and encodings.
// Forward selects, result-source codes and hazard FSM states.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } hazard_state_t;

endpackage

// File: rtl/forward_unit.sv
// ALU operand forward select for one Execute source register.
// In: rs_e, rd_m/rd_w, reg_write_m/w. Out: fwd (00 RF, 01 WB, 10 MEM).
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = (rs_e != 5'd0) &&
                 (rs_e == rd_m) &&
                 reg_write_m;
  assign hit_w = (rs_e != 5'd0) &&
                 (rs_e == rd_w) &&
                 reg_write_w;

  // Memory holds the younger value, so it wins.
  always_comb begin
    fwd = FWD_RF;
    priority case (1'b1)
      hit_m:   fwd = FWD_MEM;
      hit_w:   fwd = FWD_WB;
      default: fwd = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// memory-wait freeze with timeout, saturating stall/flush counters.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic [1:0]       result_src_e,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LIM =
    WC_W'(WAIT_MAX);

  hazard_state_t   state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       lw_stall;
  logic       mem_wait;
  logic       frozen;

  forward_unit u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_b)
  );

  assign lw_stall = (result_src_e == RESULT_LOAD) &&
                    (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) ||
                     (rd_e == rs2_d));
  assign mem_wait = mem_req_m && !mem_ready;

  // Once waiting, only mem_ready releases the freeze.
  assign frozen = (state_q == MEM_WAIT) ?
                  !mem_ready : mem_wait;

  always_comb begin
    forward_a_e = fwd_a;
    forward_b_e = fwd_b;
    stall_f     = frozen || lw_stall;
    stall_d     = frozen || lw_stall;
    stall_e     = frozen;
    stall_m     = frozen;
    flush_w     = frozen;
    flush_d     = !frozen && pc_src_e;
    flush_e     = !frozen &&
                  (pc_src_e || lw_stall);
    // Hold the pipe empty while reset is asserted.
    if (!rst_n) begin
      forward_a_e = FWD_RF;
      forward_b_e = FWD_RF;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      stall_m     = 1'b0;
      flush_w     = 1'b0;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (frozen) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!frozen) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIM) begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign err_d = err_q ||
                 (frozen && (wait_cnt_d >= WAIT_LIM));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (pc_src_e && !frozen &&
        (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign err_timeout  = err_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller.
// Uses CNT_W=4, WAIT_MAX=4 to reach saturation and timeout quickly.
module tb_hazard_controller;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic [4:0] rd_m, rd_w;
  logic       reg_write_m, reg_write_w;
  logic [1:0] result_src_e;
  logic       pc_src_e;
  logic       mem_req_m, mem_ready;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic       err_timeout;
  logic [3:0] stall_cycles, flush_count;

  int n_chk;
  int n_err;

  hazard_controller #(
    .CNT_W    (4),
    .WAIT_MAX (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .result_src_e (result_src_e),
    .pc_src_e     (pc_src_e),
    .mem_req_m    (mem_req_m),
    .mem_ready    (mem_ready),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_w      (flush_w),
    .err_timeout  (err_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0;
    rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0;
    result_src_e = 2'b00;
    pc_src_e = 0;
    mem_req_m = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  function automatic logic [6:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_w};
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    rs1_e = 5; rd_m = 5; reg_write_m = 1;
    #2;
    chk("rst_ctl", ctl(), 7'b0000110);
    chk("rst_fwd_a", forward_a_e, 2'b00);
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_flush_cnt", flush_count, 0);
    chk("rst_err", err_timeout, 0);
    #10;
    rst_n = 1'b1;
    idle();

    // Forwarding priority and x0 exclusion
    rs1_e = 5; rd_m = 5; rd_w = 5;
    reg_write_m = 1; reg_write_w = 1;
    #1;
    chk("fwd_mem_beats_wb", forward_a_e, 2'b10);
    rs1_e = 0;
    #1;
    chk("fwd_x0", forward_a_e, 2'b00);
    rs1_e = 3; rd_w = 3; rs2_e = 5;
    #1;
    chk("fwd_a_wb", forward_a_e, 2'b01);
    chk("fwd_b_mem", forward_b_e, 2'b10);
    reg_write_m = 0;
    #1;
    chk("fwd_b_no_we", forward_b_e, 2'b00);
    chk("fwd_ctl_quiet", ctl(), 7'b0000000);

    // Load-use hazard
    tick();
    idle();
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    #1;
    chk("lu_ctl", ctl(), 7'b1100010);
    chk("lu_cnt0", stall_cycles, 0);
    tick();
    idle();
    result_src_e = 2'b01; rd_e = 0;
    #1;
    chk("lu_cnt1", stall_cycles, 1);
    chk("lu_rd0_ctl", ctl(), 7'b0000000);

    // Taken branch
    tick();
    idle();
    pc_src_e = 1;
    #1;
    chk("br_ctl", ctl(), 7'b0000110);
    tick();
    idle();
    #1;
    chk("br_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_cycles, 1);

    // Branch together with load-use
    result_src_e = 2'b01; rd_e = 9; rs1_d = 9;
    pc_src_e = 1;
    #1;
    chk("br_lu_ctl", ctl(), 7'b1100110);
    tick();
    idle();
    #1;
    chk("br_lu_fcnt", flush_count, 2);
    chk("br_lu_scnt", stall_cycles, 2);

    // Memory wait, branch held in Execute
    mem_req_m = 1; mem_ready = 0; pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_ctl%0d", i), ctl(),
          7'b1111001);
      tick();
    end
    pc_src_e = 0;
    mem_ready = 1;
    #1;
    chk("mw_ready_ctl", ctl(), 7'b0000000);
    tick();
    // A MEM_WAIT state would still freeze here
    mem_req_m = 1; mem_ready = 0;
    mem_req_m = 0;
    #1;
    chk("mw_back_run", ctl(), 7'b0000000);
    chk("mw_scnt", stall_cycles, 5);
    chk("mw_fcnt", flush_count, 2);
    chk("mw_no_err", err_timeout, 0);

    // Timeout then reset mid-wait
    mem_req_m = 1; mem_ready = 0;
    tick(); tick(); tick();
    chk("to_before", err_timeout, 0);
    tick();
    chk("to_set", err_timeout, 1);
    tick();
    chk("to_sticky", err_timeout, 1);
    chk("to_still_stall", ctl(), 7'b1111001);
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", err_timeout, 0);
    chk("to_rst_ctl", ctl(), 7'b0000110);
    chk("to_rst_scnt", stall_cycles, 0);
    idle();
    #1;
    rst_n = 1'b1;
    tick();
    chk("to_post_err", err_timeout, 0);
    chk("to_post_ctl", ctl(), 7'b0000000);

    // Stall counter saturation
    result_src_e = 2'b01; rd_e = 4; rs1_d = 4;
    repeat (15) tick();
    chk("sat_15", stall_cycles, 15);
    repeat (5) tick();
    chk("sat_20", stall_cycles, 15);
    chk("sat_ctl", ctl(), 7'b1100010);

    idle();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
